// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator sequencer.
//   - State/status codes shown on the LEDs (3 bits).
//   - ALU operator codes carried from the switches to the ALU.
//   - state_is_busy(): true in every state except idle and error.
package rpn_pkg;

    localparam logic [2:0] S_IDLE      = 3'b000;
    localparam logic [2:0] S_PUSH      = 3'b001;
    localparam logic [2:0] S_ISSUE     = 3'b010;
    localparam logic [2:0] S_WAIT      = 3'b011;
    localparam logic [2:0] S_WRITEBACK = 3'b100;
    localparam logic [2:0] S_ERROR     = 3'b111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    function automatic logic state_is_busy(input logic [2:0] s);
        return (s != S_IDLE) && (s != S_ERROR);
    endfunction

endpackage

// File: rtl/rpn_operand_stack.sv
// Operand stack for the RPN sequencer: DEPTH x WIDTH register file plus an
// entry count. Entry 0 is the bottom; entry count-1 is the top.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push, push_data         write push_data into entry[count], count+1
//   replace_second_and_pop  write wb_data into entry[count-2], count-1
//   wb_data                 result written by replace_second_and_pop
//   clear                   zero every entry and the count
//   top, second             entry[count-1] / entry[count-2], 0 if absent
//   count                   current number of entries
// The controller never asks for an impossible push/pop, so no guards here
// beyond what falls out of the index match.
module rpn_operand_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       replace_second_and_pop,
    input  logic [WIDTH-1:0]           wb_data,
    input  logic                       clear,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           second,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Each entry only ever changes when the pointer lands exactly on it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            assign stack_d[gi] =
                clear                                              ? '0        :
                (push && (count_q == CW'(gi)))                     ? push_data :
                (replace_second_and_pop && (count_q == CW'(gi + 2))) ? wb_data :
                                                                     stack_q[gi];
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push) begin
            count_d = count_q + CW'(1);
        end else if (replace_second_and_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Read taps by comparison rather than count-1 indexing, so an empty or
    // single-entry stack reads as zero without an out-of-range index.
    always_comb begin
        top    = '0;
        second = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) top    = stack_q[i];
            if (count_q == CW'(i + 2)) second = stack_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rpn_stack_controller.sv
// RPN calculator sequencer with an operand stack.
// Operands/operators arrive on the Enter pulse; operators pop the top two
// entries into the external ALU (start/done handshake) and the result
// replaces them. Sticky error flags freeze the stack until the next Enter.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enter_pulse, is_op         entry strobe; 0 = operand, 1 = operator
//   data_in, op_in             operand value / operator code
//   alu_a, alu_b, alu_op       ALU operands (a = deeper entry) and opcode
//   alu_start, alu_done        one-cycle request / completion pulses
//   alu_result                 ALU result, valid with alu_done
//   top_value, depth           top entry (0 if empty) and entry count
//   busy, status               activity flag and state code for LEDs
//   err_overflow/underflow/timeout  sticky error flags
module rpn_stack_controller
    import rpn_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enter_pulse,
    input  logic                       is_op,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [1:0]                 op_in,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output logic [1:0]                 alu_op,
    output logic                       alu_start,
    input  logic                       alu_done,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [WIDTH-1:0]           top_value,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       busy,
    output logic                       err_overflow,
    output logic                       err_underflow,
    output logic                       err_timeout,
    output logic [2:0]                 status
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]       state_q,   state_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [TW-1:0]    tmo_q,     tmo_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [1:0]       alu_op_q,  alu_op_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic             err_tmo_q, err_tmo_d;

    logic             stk_push;
    logic             stk_wb;
    logic             stk_clear;
    logic [WIDTH-1:0] stk_top;
    logic [WIDTH-1:0] stk_second;
    logic [CW-1:0]    stk_count;

    rpn_operand_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk                    (clk),
        .reset                  (reset),
        .push                   (stk_push),
        .push_data              (operand_q),
        .replace_second_and_pop (stk_wb),
        .wb_data                (result_q),
        .clear                  (stk_clear),
        .top                    (stk_top),
        .second                 (stk_second),
        .count                  (stk_count)
    );

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        tmo_d     = tmo_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        err_tmo_d = err_tmo_q;
        stk_push  = 1'b0;
        stk_wb    = 1'b0;
        stk_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enter_pulse) begin
                    if (!is_op) begin
                        if (stk_count == CW'(DEPTH)) begin
                            err_ovf_d = 1'b1;
                            state_d   = S_ERROR;
                        end else begin
                            operand_d = data_in;
                            state_d   = S_PUSH;
                        end
                    end else if (stk_count < CW'(2)) begin
                        err_unf_d = 1'b1;
                        state_d   = S_ERROR;
                    end else begin
                        // The stack cannot change before the ALU sees these,
                        // so the operands are captured here and are already
                        // stable on the ALU port during the start cycle.
                        alu_a_d  = stk_second;
                        alu_b_d  = stk_top;
                        alu_op_d = op_in;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_PUSH: begin
                stk_push = 1'b1;
                state_d  = S_IDLE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last allowed cycle still wins.
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = S_WRITEBACK;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT)) begin
                        err_tmo_d = 1'b1;
                        state_d   = S_ERROR;
                    end
                end
            end
            S_WRITEBACK: begin
                stk_wb  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                if (enter_pulse) begin
                    stk_clear = 1'b1;
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                    err_tmo_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            result_q  <= '0;
            tmo_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            tmo_q     <= tmo_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign alu_start     = (state_q == S_ISSUE);
    assign top_value     = stk_top;
    assign depth         = stk_count;
    assign busy          = state_is_busy(state_q);
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign err_timeout   = err_tmo_q;
    assign status        = state_q;

endmodule
